// File: rtl/ethlite_tx_sequencer.sv
// ethlite_tx_sequencer
//   Drives one frame into the AXI EthernetLite core as its only AXI4-Lite
//   master: frame words go to the TX ping buffer, the length lands in 0x07F4,
//   the start bit is set in 0x07FC, and 0x07FC is polled until bit 0 clears.
//
// Ports
//   clk, rst              system/AXI clock, synchronous active-high reset
//   start, len_bytes      one-cycle request and frame length (no FCS)
//   word_valid/word_data  frame word source, byte 0 in [7:0]
//   word_ready            word consumed this cycle
//   busy, done, error     status; done/error are one-cycle pulses
//   m_axi_*               AXI4-Lite master towards the EthernetLite slave port
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; a bad length pulses error here
// LOAD    | copying frame words, one write outstanding at a time
// LEN     | length-register write outstanding
// GO      | control-register (TX start) write outstanding
// POLL_AR | control-register read address pending
// POLL_R  | waiting for the read data of the poll
// DONE    | one-cycle done pulse
module ethlite_tx_sequencer #(
  parameter int P_AXI_ADDR_WIDTH = 13,
  parameter int P_AXI_DATA_WIDTH = 32,
  parameter int P_POLL_LIMIT     = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [10:0]                 len_bytes,
  input  logic                        word_valid,
  input  logic [31:0]                 word_data,
  output logic                        word_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [P_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [P_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                  m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [P_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [P_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int CNT_W = $clog2(P_POLL_LIMIT + 1);
  localparam logic [P_AXI_ADDR_WIDTH-1:0] LEN_ADDR  = P_AXI_ADDR_WIDTH'(12'h7F4);
  localparam logic [P_AXI_ADDR_WIDTH-1:0] CTRL_ADDR = P_AXI_ADDR_WIDTH'(12'h7FC);
  localparam logic [CNT_W-1:0] POLL_MAX = CNT_W'(P_POLL_LIMIT);

  typedef enum logic [2:0] {
    IDLE, LOAD, LEN, GO, POLL_AR, POLL_R, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [10:0]      len_q;
  logic [8:0]       nwords_q, idx_q;
  logic [CNT_W-1:0] poll_cnt_q;
  logic             wr_out_q, err_q;

  logic start_ok, word_accept, issue_len, issue_go, issue_rd, idx_inc, fail;
  logic b_hs, r_hs;

  // Only bit 0 of the control register matters to the sequencer.
  logic unused_rdata;
  assign unused_rdata = ^m_axi_rdata[P_AXI_DATA_WIDTH-1:1];

  assign b_hs = m_axi_bvalid && wr_out_q;
  assign r_hs = m_axi_rvalid && (state_q == POLL_R);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_ok    = 1'b0;
    word_accept = 1'b0;
    issue_len   = 1'b0;
    issue_go    = 1'b0;
    issue_rd    = 1'b0;
    idx_inc     = 1'b0;
    fail        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_bytes >= 11'd1 && len_bytes <= 11'd1514) begin
            start_ok = 1'b1;
            state_d  = LOAD;
          end else begin
            fail = 1'b1;
          end
        end
      end
      LOAD: begin
        // Next word is only taken once the previous write has its B response.
        if (!wr_out_q && word_valid) word_accept = 1'b1;
        if (b_hs) begin
          if (m_axi_bresp != 2'b00) begin
            fail    = 1'b1;
            state_d = IDLE;
          end else if (idx_q == nwords_q - 9'd1) begin
            issue_len = 1'b1;
            state_d   = LEN;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      LEN: begin
        if (b_hs) begin
          if (m_axi_bresp != 2'b00) begin
            fail    = 1'b1;
            state_d = IDLE;
          end else begin
            issue_go = 1'b1;
            state_d  = GO;
          end
        end
      end
      GO: begin
        if (b_hs) begin
          if (m_axi_bresp != 2'b00) begin
            fail    = 1'b1;
            state_d = IDLE;
          end else begin
            issue_rd = 1'b1;
            state_d  = POLL_AR;
          end
        end
      end
      POLL_AR: begin
        if (m_axi_arvalid && m_axi_arready) state_d = POLL_R;
      end
      POLL_R: begin
        if (r_hs) begin
          if (m_axi_rresp != 2'b00) begin
            fail    = 1'b1;
            state_d = IDLE;
          end else if (!m_axi_rdata[0]) begin
            state_d = DONE;
          end else if (poll_cnt_q < POLL_MAX) begin
            issue_rd = 1'b1;
            state_d  = POLL_AR;
          end else begin
            fail    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q         <= '0;
      nwords_q      <= '0;
      idx_q         <= '0;
      poll_cnt_q    <= '0;
      wr_out_q      <= 1'b0;
      err_q         <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_araddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
    end else begin
      err_q <= fail;
      if (start_ok) begin
        len_q      <= len_bytes;
        nwords_q   <= 9'((len_bytes + 11'd3) >> 2);
        idx_q      <= '0;
        poll_cnt_q <= '0;
      end
      if (idx_inc) idx_q <= idx_q + 9'd1;

      // AW and W retire independently; the write stays outstanding until B.
      if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
      if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
      if (b_hs) wr_out_q <= 1'b0;

      if (word_accept) begin
        m_axi_awaddr <= P_AXI_ADDR_WIDTH'({idx_q, 2'b00});
        m_axi_wdata  <= P_AXI_DATA_WIDTH'(word_data);
      end else if (issue_len) begin
        m_axi_awaddr <= LEN_ADDR;
        m_axi_wdata  <= P_AXI_DATA_WIDTH'(len_q);
      end else if (issue_go) begin
        m_axi_awaddr <= CTRL_ADDR;
        m_axi_wdata  <= P_AXI_DATA_WIDTH'(1);
      end
      if (word_accept || issue_len || issue_go) begin
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
        wr_out_q      <= 1'b1;
      end

      if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;
      if (issue_rd) begin
        m_axi_araddr  <= CTRL_ADDR;
        m_axi_arvalid <= 1'b1;
        if (poll_cnt_q < POLL_MAX) poll_cnt_q <= poll_cnt_q + 1'b1;
      end
    end
  end

  assign word_ready   = word_accept;
  assign m_axi_wstrb  = 4'hF;
  assign m_axi_bready = wr_out_q;
  assign m_axi_rready = (state_q == POLL_R);
  assign busy         = (state_q != IDLE) && (state_q != DONE);
  assign done         = (state_q == DONE);
  assign error        = err_q;

endmodule

// File: tb/tb_ethlite_tx_sequencer.sv
module tb_ethlite_tx_sequencer;
  localparam int AW  = 13;
  localparam int DW  = 32;
  localparam int LIM = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [10:0]   len_bytes = '0;
  logic          word_valid = 1'b0;
  logic [31:0]   word_data = '0;
  logic          word_ready, busy, done, error;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0] rdata = '0;

  always #5 clk = ~clk;

  ethlite_tx_sequencer #(
    .P_AXI_ADDR_WIDTH(AW), .P_AXI_DATA_WIDTH(DW), .P_POLL_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len_bytes(len_bytes),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .busy(busy), .done(done), .error(error),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;
  wr_t exp_q[$];

  function automatic logic [31:0] pat(input int f, input int i);
    return {8'(f), 8'(i), 8'(i ^ 8'h5A), 8'(f * 7 + i)};
  endfunction

  // slave configuration
  int aw_lat = 0, w_lat = 0, berr_at = -1, poll_ones = 0;
  bit rnd_b = 0;
  // slave state
  bit aw_taken = 0, w_taken = 0, b_wait = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, wr_idx = 0, rd_count = 0;
  logic [AW-1:0] cap_addr, hs_addr;
  logic [31:0]   cap_data, hs_data;
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
  // word source
  bit feed_en = 0;
  int feed_id = 0, feed_n = 0, feed_idx = 0;
  // monitors
  int done_cnt = 0, err_cnt = 0, wr_cnt = 0, awv_cycles = 0, proto_bad = 0;
  int cyc = 0, last_wr = -1, max_gap = 0;

  // Handshakes are recorded with the values present at the active edge.
  always @(posedge clk) begin
    cyc++;
    aw_hs = !rst && awvalid && awready;
    w_hs  = !rst && wvalid && wready;
    b_hs  = !rst && bvalid && bready;
    ar_hs = !rst && arvalid && arready;
    r_hs  = !rst && rvalid && rready;
    if (aw_hs) hs_addr = awaddr;
    if (w_hs)  hs_data = wdata;
    if (!rst) begin
      if (done)  done_cnt++;
      if (error) err_cnt++;
      if (awvalid) awv_cycles++;
      if (done && (busy || error)) proto_bad++;
      if (error && busy) proto_bad++;
      if (wvalid && wstrb !== 4'hF) proto_bad++;
      if (word_valid && word_ready) begin
        wr_cnt++;
        feed_idx++;
        if (last_wr >= 0 && cyc - last_wr > max_gap) max_gap = cyc - last_wr;
        last_wr = cyc;
      end
    end
  end

  // Slave responses and the word source change on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0;
      aw_taken = 0; w_taken = 0; b_wait = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (b_hs) begin
        bvalid = 0; bresp = 0; aw_taken = 0; w_taken = 0; wr_idx++;
      end
      if (aw_hs) begin
        awready = 0; aw_taken = 1; cap_addr = hs_addr; aw_cnt = 0;
      end else if (awvalid && !awready && !aw_taken) begin
        if (aw_cnt >= aw_lat) awready = 1; else aw_cnt++;
      end
      if (w_hs) begin
        wready = 0; w_taken = 1; cap_data = hs_data; w_cnt = 0;
      end else if (wvalid && !wready && !w_taken) begin
        if (w_cnt >= w_lat) wready = 1; else w_cnt++;
      end
      if (aw_taken && w_taken && !b_wait && !bvalid) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_write_addr", 32'(cap_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(cap_addr), 32'(e.a));
          check("wr_data", cap_data, e.d);
        end
        b_wait = 1;
        b_cnt  = rnd_b ? int'($urandom_range(0, 5)) : 0;
      end
      if (b_wait) begin
        if (b_cnt == 0) begin
          bvalid = 1;
          bresp  = (wr_idx == berr_at) ? 2'b10 : 2'b00;
          b_wait = 0;
        end else begin
          b_cnt--;
        end
      end
      if (r_hs) rvalid = 0;
      if (ar_hs) begin
        arready = 0;
        rd_count++;
        rvalid = 1;
        rresp  = 2'b00;
        rdata  = {31'h0, (rd_count <= poll_ones)};
      end else if (arvalid && !arready && !rvalid) begin
        arready = 1;
      end
    end
    word_valid = feed_en && (feed_idx < feed_n);
    word_data  = pat(feed_id, feed_idx);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    done_cnt = 0; err_cnt = 0; wr_cnt = 0; awv_cycles = 0; proto_bad = 0;
    last_wr = -1; max_gap = 0; rd_count = 0; wr_idx = 0;
  endtask

  task automatic push_frame(input int f, input int len, input int nw_limit);
    int nw = (len + 3) / 4;
    for (int i = 0; i < nw && i < nw_limit; i++) exp_q.push_back({AW'(i * 4), pat(f, i)});
    if (nw_limit >= nw) begin
      exp_q.push_back({AW'(12'h7F4), 32'(len)});
      exp_q.push_back({AW'(12'h7FC), 32'h1});
    end
  endtask

  task automatic start_frame(input int f, input int len, input bit feed);
    clear_mon();
    feed_id = f; feed_n = (len + 3) / 4; feed_idx = 0; feed_en = feed;
    start = 1; len_bytes = 11'(len);
    step(1);
    start = 0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int base = done_cnt + err_cnt;
    int n = 0;
    while ((done_cnt + err_cnt) == base && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_end_seen"}, 32'((done_cnt + err_cnt) != base), 32'd1);
    step(3);
  endtask

  initial begin
    // reset state
    step(3);
    check("rst_valids", {27'h0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
    check("rst_status", {28'h0, word_ready, busy, done, error}, 32'h0);
    check("rst_regs", {3'h0, awaddr, araddr, 3'h0}, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_wstrb", 32'(wstrb), 32'hF);
    rst = 0;
    step(2);

    // 60-byte frame, zero-wait slave, two busy polls
    poll_ones = 2;
    push_frame(1, 60, 1000);
    start_frame(1, 60, 1);
    check("f60_busy_after_start", 32'(busy), 32'd1);
    wait_end("f60", 2000);
    check("f60_done", done_cnt, 1);
    check("f60_err", err_cnt, 0);
    check("f60_reads", rd_count, 3);
    check("f60_words", wr_cnt, 15);
    check("f60_sb_left", exp_q.size(), 0);
    check("f60_busy_after", 32'(busy), 32'd0);
    check("f60_accept_gap_le4", 32'(max_gap <= 4), 32'd1);
    check("f60_proto", proto_bad, 0);

    // 61-byte frame rounds up to 16 words
    poll_ones = 0;
    push_frame(2, 61, 1000);
    start_frame(2, 61, 1);
    wait_end("f61", 2000);
    check("f61_done", done_cnt, 1);
    check("f61_words", wr_cnt, 16);
    check("f61_reads", rd_count, 1);
    check("f61_sb_left", exp_q.size(), 0);

    // rejected lengths
    start_frame(3, 0, 0);
    check("len0_busy", 32'(busy), 32'd0);
    step(4);
    check("len0_err", err_cnt, 1);
    check("len0_done", done_cnt, 0);
    check("len0_awvalid", awv_cycles, 0);
    start_frame(3, 1515, 0);
    check("len1515_busy", 32'(busy), 32'd0);
    step(4);
    check("len1515_err", err_cnt, 1);
    check("len1515_awvalid", awv_cycles, 0);

    // skewed AW/W readiness, random B latency
    aw_lat = 0; w_lat = 3; rnd_b = 1; poll_ones = 1;
    push_frame(4, 40, 1000);
    start_frame(4, 40, 1);
    wait_end("skew", 3000);
    check("skew_done", done_cnt, 1);
    check("skew_words", wr_cnt, 10);
    check("skew_reads", rd_count, 2);
    check("skew_sb_left", exp_q.size(), 0);
    check("skew_proto", proto_bad, 0);
    w_lat = 0; rnd_b = 0;

    // BRESP error on word 4
    berr_at = 4; poll_ones = 0;
    push_frame(5, 60, 5);
    start_frame(5, 60, 1);
    wait_end("berr", 2000);
    check("berr_err", err_cnt, 1);
    check("berr_done", done_cnt, 0);
    check("berr_words", wr_cnt, 5);
    check("berr_sb_left", exp_q.size(), 0);
    check("berr_busy", 32'(busy), 32'd0);
    berr_at = -1;
    push_frame(6, 8, 1000);
    start_frame(6, 8, 1);
    wait_end("after_berr", 2000);
    check("after_berr_done", done_cnt, 1);
    check("after_berr_sb_left", exp_q.size(), 0);

    // control bit stuck at 1
    poll_ones = 1000;
    push_frame(7, 4, 1000);
    start_frame(7, 4, 1);
    wait_end("stuck", 2000);
    check("stuck_reads", rd_count, LIM);
    check("stuck_err", err_cnt, 1);
    check("stuck_done", done_cnt, 0);
    check("stuck_sb_left", exp_q.size(), 0);

    // reset while awvalid is high in LOAD
    poll_ones = 0; aw_lat = 6;
    start_frame(8, 20, 1);
    begin
      int n = 0;
      while (!awvalid && n < 50) begin
        step(1);
        n++;
      end
    end
    check("rst_mid_awvalid_seen", 32'(awvalid), 32'd1);
    rst = 1;
    step(1);
    check("rst_mid_valids", {27'h0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
    check("rst_mid_status", {29'h0, busy, done, error}, 32'h0);
    step(1);
    rst = 0;
    exp_q.delete();
    step(3);
    check("rst_mid_done", done_cnt, 0);
    check("rst_mid_err", err_cnt, 0);
    aw_lat = 0;
    push_frame(9, 8, 1000);
    start_frame(9, 8, 1);
    wait_end("after_rst", 2000);
    check("after_rst_done", done_cnt, 1);
    check("after_rst_sb_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
